// File: rtl/hls_deadlock_pkg.sv
// Shared types and helpers for the per-level HLS deadlock monitor.
//   mon_state_e : FSM encoding exported on mon_state (IDLE=0, SUSPECT=1, DEADLOCK=2)
//   stall_term  : final reduction of the per-level stall term
package hls_deadlock_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    MON_IDLE     = 2'd0,
    MON_SUSPECT  = 2'd1,
    MON_DEADLOCK = 2'd2
  } mon_state_e;

  // A stall only counts while at least one instance is still busy.
  function automatic logic stall_term(input logic all_idle,
                                      input logic cur_hit,
                                      input logic sub_hit);
    return ~all_idle & (cur_hit | sub_hit);
  endfunction

endpackage

// File: rtl/hls_deadlock_persist_cnt.sv
// Saturating persistence counter with synchronous clear and registered terminal flag.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clr_i        : zero the count (wins over inc_i)
//   inc_i        : count up by one, saturating at all-ones
//   term_o       : registered flag, high while the count equals TERM
module hls_deadlock_persist_cnt #(
  parameter int unsigned W    = 1,
  parameter int unsigned TERM = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic term_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         term_q;

  // Next count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count and terminal flag registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      term_q <= (TERM == 0);
    end else begin
      cnt_q  <= cnt_d;
      term_q <= (cnt_d == W'(TERM));
    end
  end

  assign term_o = term_q;

endmodule

// File: rtl/hls_deadlock_monitor_param.sv
// Per-level HLS deadlock monitor: combines this level's AXIS stalls with qualified child
// block flags, filters with a persistence threshold, and raises a sticky or self-clearing block.
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   enable           : monitoring on/off (ignored once a sticky block has fired)
//   clear            : one-cycle pulse, drops block and returns to IDLE
//   axis_block_sigs  : per-channel AXIS stall indications
//   inst_idle_sigs   : per-instance idle; all idle forces stall low
//   inst_block_sigs  : forwarded to child monitors elsewhere, not used here
//   sub_block        : block outputs of child monitors
//   block            : registered deadlock flag
//   block_snapshot   : axis_block_sigs captured on DEADLOCK entry
//   deadlock_cycles  : saturating count of cycles spent in DEADLOCK
//   mon_state        : current FSM state
module hls_deadlock_monitor_param
  import hls_deadlock_pkg::*;
#(
  parameter int unsigned                     NUM_AXIS      = 4,
  parameter int unsigned                     NUM_INST      = 4,
  parameter int unsigned                     NUM_SUB       = 1,
  parameter logic [NUM_AXIS-1:0]             CUR_AXIS_MASK = 4'b0001,
  parameter logic [NUM_SUB*NUM_AXIS-1:0]     SUB_AXIS_MASK = 4'b1010,
  parameter int unsigned                     THRESHOLD     = 1,
  parameter bit                              STICKY        = 1'b0,
  parameter int unsigned                     DUR_W         = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [NUM_AXIS-1:0]  axis_block_sigs,
  input  logic [NUM_INST-1:0]  inst_idle_sigs,
  input  logic [NUM_SUB-1:0]   inst_block_sigs,
  input  logic [NUM_SUB-1:0]   sub_block,
  output logic                 block,
  output logic [NUM_AXIS-1:0]  block_snapshot,
  output logic [DUR_W-1:0]     deadlock_cycles,
  output logic [STATE_W-1:0]   mon_state
);

  localparam int unsigned CNT_W = $clog2(THRESHOLD + 1);

  localparam logic [STATE_W-1:0] ST_IDLE     = MON_IDLE;
  localparam logic [STATE_W-1:0] ST_SUSPECT  = MON_SUSPECT;
  localparam logic [STATE_W-1:0] ST_DEADLOCK = MON_DEADLOCK;

  logic [STATE_W-1:0]  state_q, state_d;
  logic                block_q;
  logic [NUM_AXIS-1:0] snap_q;
  logic [DUR_W-1:0]    dur_q;
  logic                cur_hit, sub_hit, stall;
  logic                cnt_term, cnt_inc;
  logic                dl_entry;
  logic                unused_inst_block;

  assign unused_inst_block = ^inst_block_sigs;

  // Stall term: own channels, or a blocked child whose qualifying channels are stalled
  always_comb begin
    cur_hit = |(axis_block_sigs & CUR_AXIS_MASK);
    sub_hit = 1'b0;
    for (int unsigned s = 0; s < NUM_SUB; s++) begin
      sub_hit = sub_hit |
                (sub_block[s] & (|(axis_block_sigs & SUB_AXIS_MASK[s*NUM_AXIS +: NUM_AXIS])));
    end
    stall = stall_term(&inst_idle_sigs, cur_hit, sub_hit);
  end

  // Next-state logic; clear overrides every state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && stall) begin
          state_d = (THRESHOLD == 1) ? ST_DEADLOCK : ST_SUSPECT;
        end
      end
      ST_SUSPECT: begin
        if (!enable || !stall) begin
          state_d = ST_IDLE;
        end else if (cnt_term) begin
          state_d = ST_DEADLOCK;
        end
      end
      ST_DEADLOCK: begin
        if (!STICKY && (!enable || !stall)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear) begin
      state_d = ST_IDLE;
    end
  end

  // Counter advances only while (re)entering SUSPECT; anything else restarts it
  assign cnt_inc  = (state_d == ST_SUSPECT);
  assign dl_entry = (state_d == ST_DEADLOCK) && (state_q != ST_DEADLOCK);

  hls_deadlock_persist_cnt #(
    .W    (CNT_W),
    .TERM (THRESHOLD - 1)
  ) u_persist_cnt (
    .clock  (clock),
    .reset  (reset),
    .clr_i  (!cnt_inc),
    .inc_i  (cnt_inc),
    .term_o (cnt_term)
  );

  // State, block flag and debug capture registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      block_q <= 1'b0;
      snap_q  <= '0;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      block_q <= (state_d == ST_DEADLOCK);
      if (dl_entry) begin
        snap_q <= axis_block_sigs;
        dur_q  <= '0;
      end else if ((state_q == ST_DEADLOCK) && (dur_q != '1)) begin
        dur_q  <= dur_q + DUR_W'(1);
      end
    end
  end

  assign block           = block_q;
  assign block_snapshot  = snap_q;
  assign deadlock_cycles = dur_q;
  assign mon_state       = state_q;

endmodule

// File: tb/tb_hls_deadlock_monitor_param.sv
// Scoreboard bench: three monitor configurations share one stimulus stream; a streak-based
// reference model predicts each cycle's outputs, and a monitor process compares them.
module tb_hls_deadlock_monitor_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset  = 1'b1;
  logic       enable = 1'b0;
  logic       clear  = 1'b0;
  logic [3:0] axis   = '0;
  logic [3:0] idle   = '0;
  logic [1:0] sub    = '0;
  logic [1:0] iblk   = '0;

  logic        blk_a, blk_b, blk_c;
  logic [3:0]  snap_a, snap_b, snap_c;
  logic [31:0] dur_a, dur_c;
  logic [3:0]  dur_b;
  logic [1:0]  st_a, st_b, st_c;

  // A: threshold 1, self-clearing
  hls_deadlock_monitor_param #(
    .NUM_AXIS(4), .NUM_INST(4), .NUM_SUB(1), .CUR_AXIS_MASK(4'b0001), .SUB_AXIS_MASK(4'b1010),
    .THRESHOLD(1), .STICKY(1'b0), .DUR_W(32)
  ) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(iblk[0:0]),
    .sub_block(sub[0:0]), .block(blk_a), .block_snapshot(snap_a),
    .deadlock_cycles(dur_a), .mon_state(st_a)
  );

  // B: threshold 8, self-clearing, 4-bit duration counter
  hls_deadlock_monitor_param #(
    .NUM_AXIS(4), .NUM_INST(4), .NUM_SUB(1), .CUR_AXIS_MASK(4'b0001), .SUB_AXIS_MASK(4'b1010),
    .THRESHOLD(8), .STICKY(1'b0), .DUR_W(4)
  ) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(iblk[0:0]),
    .sub_block(sub[0:0]), .block(blk_b), .block_snapshot(snap_b),
    .deadlock_cycles(dur_b), .mon_state(st_b)
  );

  // C: threshold 3, sticky, two children
  hls_deadlock_monitor_param #(
    .NUM_AXIS(4), .NUM_INST(4), .NUM_SUB(2), .CUR_AXIS_MASK(4'b0001),
    .SUB_AXIS_MASK(8'b0100_1010), .THRESHOLD(3), .STICKY(1'b1), .DUR_W(32)
  ) dut_c (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(iblk),
    .sub_block(sub), .block(blk_c), .block_snapshot(snap_c),
    .deadlock_cycles(dur_c), .mon_state(st_c)
  );

  typedef struct packed {
    logic [1:0]  st;
    logic        blk;
    logic [3:0]  snap;
    logic [31:0] dur;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: a deadlock is a run of >= threshold consecutive enabled stall cycles
  int          th   [3] = '{1, 8, 3};
  bit          stk  [3] = '{1'b0, 1'b0, 1'b1};
  int          nsub [3] = '{1, 1, 2};
  logic [31:0] dmax [3] = '{32'hFFFF_FFFF, 32'd15, 32'hFFFF_FFFF};
  int          streak [3];
  bit          latched[3];
  bit          dl     [3];
  logic [3:0]  msnap  [3];
  logic [31:0] mdur   [3];

  function automatic bit calc_stall(input int k, input logic [3:0] ax, input logic [3:0] id,
                                    input logic [1:0] sb);
    logic [3:0] qual [2];
    qual[0] = 4'b1010;
    qual[1] = 4'b0100;
    if (id == 4'hF) return 1'b0;
    if ((ax & 4'b0001) != 4'b0000) return 1'b1;
    for (int s = 0; s < nsub[k]; s++) begin
      if (sb[s] && ((ax & qual[s]) != 4'b0000)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_step(input int k, input bit rst, input bit en, input bit clr,
                            input logic [3:0] ax, input logic [3:0] id, input logic [1:0] sb,
                            output exp_t e);
    bit s;
    bit now_dl;
    if (rst) begin
      streak[k] = 0; latched[k] = 1'b0; dl[k] = 1'b0; msnap[k] = '0; mdur[k] = '0;
    end else begin
      s = calc_stall(k, ax, id, sb);
      if (clr) begin
        streak[k] = 0; latched[k] = 1'b0; now_dl = 1'b0;
      end else begin
        streak[k] = (en && s) ? ((streak[k] >= th[k]) ? th[k] : streak[k] + 1) : 0;
        now_dl = (streak[k] >= th[k]) || (stk[k] && latched[k]);
        latched[k] = now_dl;
      end
      if (now_dl && !dl[k]) begin
        msnap[k] = ax; mdur[k] = '0;
      end else if (dl[k] && (mdur[k] != dmax[k])) begin
        mdur[k] = mdur[k] + 32'd1;
      end
      dl[k] = now_dl;
    end
    e.st   = dl[k] ? 2'd2 : ((streak[k] > 0) ? 2'd1 : 2'd0);
    e.blk  = dl[k];
    e.snap = msnap[k];
    e.dur  = mdur[k];
  endtask

  // Drive one cycle of stimulus and queue the expected post-edge outputs
  task automatic step(input bit rst, input bit en, input bit clr, input logic [3:0] ax,
                      input logic [3:0] id, input logic [1:0] sb);
    exp_t e;
    @(negedge clock);
    reset = rst; enable = en; clear = clr; axis = ax; idle = id; sub = sb;
    iblk = 2'($urandom);
    model_step(0, rst, en, clr, ax, id, sb, e); qa.push_back(e);
    model_step(1, rst, en, clr, ax, id, sb, e); qb.push_back(e);
    model_step(2, rst, en, clr, ax, id, sb, e); qc.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
  endtask

  task automatic chk(input string tag, input exp_t e, input logic [1:0] st, input logic b,
                     input logic [3:0] sn, input logic [31:0] d);
    cmp({tag, ".mon_state"}, 32'(st), 32'(e.st));
    cmp({tag, ".block"}, 32'(b), 32'(e.blk));
    cmp({tag, ".block_snapshot"}, 32'(sn), 32'(e.snap));
    cmp({tag, ".deadlock_cycles"}, d, e.dur);
  endtask

  // Monitor: every edge presents outputs; pop and compare just after it
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (qa.size() > 0) begin e = qa.pop_front(); chk("A", e, st_a, blk_a, snap_a, dur_a); end
      if (qb.size() > 0) begin e = qb.pop_front(); chk("B", e, st_b, blk_b, snap_b, 32'(dur_b)); end
      if (qc.size() > 0) begin e = qc.pop_front(); chk("C", e, st_c, blk_c, snap_c, dur_c); end
    end
  end

  initial begin
    logic [3:0] r_ax, r_id;
    logic [1:0] r_sb;
    int         len;

    repeat (2) step(1, 0, 0, 4'b0000, 4'b0000, 2'b00);

    // single-cycle pulse on channel 0
    step(0, 1, 0, 4'b0001, 4'b0000, 2'b00);
    repeat (3) step(0, 1, 0, 4'b0000, 4'b0000, 2'b00);

    // stall one short of threshold 8
    repeat (7) step(0, 1, 0, 4'b0001, 4'b0000, 2'b00);
    repeat (3) step(0, 1, 0, 4'b0000, 4'b0000, 2'b00);

    // held stall: fire, count, saturate the 4-bit counter, then reset mid-deadlock
    repeat (26) step(0, 1, 0, 4'b0001, 4'b0000, 2'b00);
    step(1, 1, 0, 4'b0001, 4'b0000, 2'b00);
    repeat (2) step(0, 1, 0, 4'b0000, 4'b0000, 2'b00);

    // sticky hold through all-idle and enable low, then clear (with stall present)
    repeat (5) step(0, 1, 0, 4'b0011, 4'b0000, 2'b00);
    repeat (4) step(0, 1, 0, 4'b0001, 4'b1111, 2'b00);
    repeat (2) step(0, 0, 0, 4'b0000, 4'b0000, 2'b00);
    step(0, 1, 1, 4'b0001, 4'b0000, 2'b00);
    repeat (4) step(0, 1, 0, 4'b0001, 4'b0000, 2'b00);
    step(0, 1, 1, 4'b0000, 4'b0000, 2'b00);
    repeat (2) step(0, 1, 0, 4'b0000, 4'b0000, 2'b00);

    // child-qualified stalls
    repeat (10) step(0, 1, 0, 4'b0010, 4'b0000, 2'b01);
    repeat (10) step(0, 1, 0, 4'b0100, 4'b0000, 2'b01);
    step(0, 1, 1, 4'b0000, 4'b0000, 2'b00);
    repeat (6) step(0, 1, 0, 4'b0100, 4'b0000, 2'b10);
    step(0, 1, 1, 4'b0000, 4'b0000, 2'b00);

    // randomized bursts of held inputs with occasional enable drop, clear and reset
    for (int b = 0; b < 60; b++) begin
      r_ax = 4'($urandom);
      r_id = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      r_sb = 2'($urandom);
      len  = $urandom_range(1, 14);
      for (int c = 0; c < len; c++) begin
        step(($urandom_range(0, 120) == 0), ($urandom_range(0, 9) != 0),
             ($urandom_range(0, 30) == 0), r_ax, r_id, r_sb);
      end
    end

    // drain outstanding expectations
    repeat (2) @(posedge clock);
    #2;
    n_total++;
    if ((qa.size() == 0) && (qb.size() == 0) && (qc.size() == 0)) n_pass++;
    else $display("FAIL drain pending=%0d want=0", qa.size() + qb.size() + qc.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
